fifo_flex: RTL and testbench
============================

// Module: fifo_flex
// PURPOSE
//  Parametrised single-clock FIFO for the NPU datapath (pixel/weight/activation staging between loader, PE array and
//  classifier output). Next generation of the basic NPU FIFO: adds first-word-fall-through mode, level output,
//  programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_WIDTH     8            word width in bits (>=1)
//  DEPTH          128          entries; power of 2, >=4
//  FWFT           0            0 = registered-read mode, 1 = first-word-fall-through mode
//  AFULL_THRESH   DEPTH-4      ALMOST_FULL asserted when LEVEL >= AFULL_THRESH (1..DEPTH)
//  AEMPTY_THRESH  4            ALMOST_EMPTY asserted when LEVEL <= AEMPTY_THRESH (0..DEPTH-1)
// PORTS
//  CLKEXT        in   1                  clock, all state on rising edge
//  RST_N         in   1                  reset, asynchronous, active-low
//  FLUSH         in   1                  synchronous empty request
//  WR_EN         in   1                  write request
//  DATA_IN       in   DATA_WIDTH         write data
//  RD_EN         in   1                  read request (FWFT=1: pop/acknowledge of head word)
//  DATA_OUT      out  DATA_WIDTH         read data
//  DATA_VALID    out  1                  DATA_OUT holds a newly delivered (FWFT=0) / current head (FWFT=1) word
//  FULL          out  1                  LEVEL == DEPTH
//  EMPTY         out  1                  LEVEL == 0
//  ALMOST_FULL   out  1                  LEVEL >= AFULL_THRESH
//  ALMOST_EMPTY  out  1                  LEVEL <= AEMPTY_THRESH
//  LEVEL         out  $clog2(DEPTH)+1    stored word count, 0..DEPTH
//  OVERFLOW      out  1                  sticky: write rejected
//  UNDERFLOW     out  1                  sticky: read rejected
//  ERR_CLR       in   1                  clears OVERFLOW/UNDERFLOW
// BEHAVIOUR
//  - Reset (RST_N=0, async): pointers 0, LEVEL 0, DATA_OUT 0, DATA_VALID 0, OVERFLOW 0, UNDERFLOW 0;
//    hence EMPTY 1, FULL 0, ALMOST_EMPTY 1, ALMOST_FULL 0. Memory contents not reset. Mid-operation reset drops all data.
//  - Flags FULL/EMPTY/ALMOST_* are combinational decodes of registered LEVEL only (no input-to-flag paths).
//  - rd_ok = RD_EN & !EMPTY. wr_ok = WR_EN & (!FULL | rd_ok): write on full accepted only when a read pops same cycle.
//  - Read-on-empty rejected even if a write occurs same cycle (new word visible no earlier than next cycle).
//  - LEVEL: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither. Never exceeds DEPTH or drops below 0.
//  - Pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally. Full+read+write: old head read, new word written same slot.
//  - FWFT=0: rd_ok -> DATA_OUT = oldest word at next edge, DATA_VALID=1 for exactly that cycle; else DATA_VALID=0 and
//    DATA_OUT holds last value. Read latency 1 cycle.
//  - FWFT=1: DATA_OUT = mem[rd_ptr] whenever !EMPTY, DATA_VALID = !EMPTY. Write-to-visible latency 1 cycle (word written
//    at edge N into empty FIFO is on DATA_OUT after edge N). rd_ok pops; next word (if any) shown after same edge.
//    DATA_OUT undefined-but-stable content when EMPTY; consumers gate on DATA_VALID.
//  - OVERFLOW set when WR_EN & !wr_ok; UNDERFLOW set when RD_EN & !rd_ok. Cleared by ERR_CLR; set wins over ERR_CLR
//    in the same cycle. Flags not affected by FLUSH.
//  - FLUSH=1: at next edge pointers and LEVEL -> 0, DATA_VALID -> 0; WR_EN/RD_EN that cycle ignored and raise no error
//    flags. FWFT=0 DATA_OUT keeps last value. FLUSH has priority over all other requests.
//  - Parameter checks: DEPTH not power of 2 or thresholds out of range -> elaboration error.
// TESTING
//  - Reset: RST_N low mid-burst with LEVEL=37 -> immediately LEVEL 0, EMPTY 1, DATA_VALID 0, OVERFLOW/UNDERFLOW 0.
//  - FWFT=0, DEPTH=8: write 0x11..0x18 -> FULL=1, ALMOST_FULL from LEVEL 4; 9th write -> OVERFLOW=1, LEVEL stays 8;
//    8 reads -> DATA_OUT 0x11..0x18 each 1 cycle after RD_EN with DATA_VALID pulse; then EMPTY=1.
//  - Full + simultaneous RD_EN/WR_EN(0xAA): head popped, LEVEL stays 8, 0xAA emerges as 8th subsequent read; no OVERFLOW.
//  - Empty + simultaneous RD_EN/WR_EN(0x5C): UNDERFLOW=1, LEVEL 1; ERR_CLR with RD_EN on empty same cycle -> UNDERFLOW stays 1.
//  - FWFT=1: write 0x3C into empty -> next cycle DATA_OUT=0x3C, DATA_VALID=1; RD_EN -> DATA_VALID 0, EMPTY 1.
//  - Random 10k-cycle traffic, both modes, DEPTH 4 and 128, with FLUSH/ERR_CLR: scoreboard order, LEVEL, all flags, wrap.

Source files
------------

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO with registered-read or first-word-fall-through
// output, level/threshold flags, synchronous flush and sticky overflow/underflow flags.
module fifo_flex #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 128,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                     CLKEXT,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     WR_EN,
  input  logic [DATA_WIDTH-1:0]    DATA_IN,
  input  logic                     RD_EN,
  output logic [DATA_WIDTH-1:0]    DATA_OUT,
  output logic                     DATA_VALID,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  input  logic                     ERR_CLR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  // Reject illegal configurations at elaboration time
  if (DATA_WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_flex: DATA_WIDTH must be >=1 and DEPTH a power of 2 >= 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_thresh
    $error("fifo_flex: AFULL_THRESH must be 1..DEPTH and AEMPTY_THRESH 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  rd_do;
  logic                  wr_do;
  logic                  ovf_set;
  logic                  unf_set;

  // Flags decode only the registered level
  assign LEVEL        = level;
  assign FULL         = (level == LW'(DEPTH));
  assign EMPTY        = (level == '0);
  assign ALMOST_FULL  = (level >= LW'(AFULL_THRESH));
  assign ALMOST_EMPTY = (level <= LW'(AEMPTY_THRESH));

  // Request qualification; a write on full is legal only alongside a pop, flush masks everything
  always_comb begin
    rd_ok   = RD_EN & ~EMPTY;
    wr_ok   = WR_EN & (~FULL | rd_ok);
    rd_do   = rd_ok & ~FLUSH;
    wr_do   = wr_ok & ~FLUSH;
    ovf_set = ~FLUSH & WR_EN & ~wr_ok;
    unf_set = ~FLUSH & RD_EN & ~rd_ok;
  end

  // Pointers and level
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + AW'(1);
      if (rd_do) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_do, rd_do})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array, not reset
  always_ff @(posedge CLKEXT) begin
    if (wr_do) mem[wr_ptr] <= DATA_IN;
  end

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (ovf_set)      OVERFLOW <= 1'b1;
      else if (ERR_CLR) OVERFLOW <= 1'b0;
      if (unf_set)      UNDERFLOW <= 1'b1;
      else if (ERR_CLR) UNDERFLOW <= 1'b0;
    end
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dvalid_q;

    // Registered read: one-cycle valid pulse per accepted pop, data held otherwise
    always_ff @(posedge CLKEXT or negedge RST_N) begin
      if (!RST_N) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dvalid_q <= rd_do;
        if (rd_do) dout_q <= mem[rd_ptr];
      end
    end

    assign DATA_OUT   = dout_q;
    assign DATA_VALID = dvalid_q;
  end else begin : g_fwft
    // Head word presented straight from storage; forced to zero while empty so it stays defined
    assign DATA_OUT   = EMPTY ? '0 : mem[rd_ptr];
    assign DATA_VALID = ~EMPTY;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: five fifo_flex configurations driven by one shared stimulus stream and
// checked every cycle against a queue-based model of the FIFO rules.
module tb_fifo_flex;

  localparam int NI = 5;
  localparam int DEP [NI] = '{8, 4, 128, 128, 4};
  localparam int FW  [NI] = '{0, 1, 0, 1, 0};
  localparam int AF  [NI] = '{4, 3, 100, 124, 3};
  localparam int AE  [NI] = '{4, 1, 20, 4, 0};

  logic clk;
  logic rst_n;
  logic flush;
  logic wr;
  logic rd;
  logic clr;
  logic [7:0] din;

  logic [NI-1:0][7:0] d_out;
  logic [NI-1:0][8:0] d_lv;
  logic [NI-1:0]      d_dv;
  logic [NI-1:0]      d_full;
  logic [NI-1:0]      d_empty;
  logic [NI-1:0]      d_af;
  logic [NI-1:0]      d_ae;
  logic [NI-1:0]      d_ovf;
  logic [NI-1:0]      d_unf;

  // Model state
  logic [7:0] mq [NI][$];
  logic [7:0] m_dout [NI];
  logic       m_dv   [NI];
  logic       m_ovf  [NI];
  logic       m_unf  [NI];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LW = $clog2(DEP[g]) + 1;
    logic [LW-1:0] lv;
    fifo_flex #(
      .DATA_WIDTH   (8),
      .DEPTH        (DEP[g]),
      .FWFT         (FW[g]),
      .AFULL_THRESH (AF[g]),
      .AEMPTY_THRESH(AE[g])
    ) u_dut (
      .CLKEXT      (clk),
      .RST_N       (rst_n),
      .FLUSH       (flush),
      .WR_EN       (wr),
      .DATA_IN     (din),
      .RD_EN       (rd),
      .DATA_OUT    (d_out[g]),
      .DATA_VALID  (d_dv[g]),
      .FULL        (d_full[g]),
      .EMPTY       (d_empty[g]),
      .ALMOST_FULL (d_af[g]),
      .ALMOST_EMPTY(d_ae[g]),
      .LEVEL       (lv),
      .OVERFLOW    (d_ovf[g]),
      .UNDERFLOW   (d_unf[g]),
      .ERR_CLR     (clr)
    );
    assign d_lv[g] = 9'(lv);
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      m_dout[i] = 8'h00;
      m_dv[i]   = 1'b0;
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
    end
  endtask

  // One clock edge of FIFO behaviour, from the inputs held across that edge
  task automatic model_step();
    int n;
    bit e;
    bit f;
    bit rok;
    bit wok;
    logic [7:0] h;
    for (int i = 0; i < NI; i++) begin
      n = mq[i].size();
      e = (n == 0);
      f = (n == DEP[i]);
      if (flush) begin
        mq[i].delete();
        m_dv[i] = 1'b0;
        if (clr) begin
          m_ovf[i] = 1'b0;
          m_unf[i] = 1'b0;
        end
      end else begin
        rok = rd && !e;
        wok = wr && (!f || rok);
        m_dv[i] = 1'b0;
        if (rok) begin
          h = mq[i].pop_front();
          if (FW[i] == 0) begin
            m_dout[i] = h;
            m_dv[i]   = 1'b1;
          end
        end
        if (wok) mq[i].push_back(din);
        if (wr && !wok)   m_ovf[i] = 1'b1;
        else if (clr)     m_ovf[i] = 1'b0;
        if (rd && !rok)   m_unf[i] = 1'b1;
        else if (clr)     m_unf[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    int n;
    for (int i = 0; i < NI; i++) begin
      n = mq[i].size();
      chk("level", i, 32'(d_lv[i]), 32'(n));
      chk("full", i, 32'(d_full[i]), 32'(n == DEP[i]));
      chk("empty", i, 32'(d_empty[i]), 32'(n == 0));
      chk("almost_full", i, 32'(d_af[i]), 32'(n >= AF[i]));
      chk("almost_empty", i, 32'(d_ae[i]), 32'(n <= AE[i]));
      chk("overflow", i, 32'(d_ovf[i]), 32'(m_ovf[i]));
      chk("underflow", i, 32'(d_unf[i]), 32'(m_unf[i]));
      if (FW[i] == 0) begin
        chk("data_valid", i, 32'(d_dv[i]), 32'(m_dv[i]));
        chk("data_out", i, 32'(d_out[i]), 32'(m_dout[i]));
      end else begin
        chk("data_valid", i, 32'(d_dv[i]), 32'(n != 0));
        if (n != 0) chk("data_out", i, 32'(d_out[i]), 32'(mq[i][0]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  initial begin
    logic [7:0] exp_rd [8];
    int pw;
    int pr;
    rst_n = 1'b0;
    flush = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    clr   = 1'b0;
    din   = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_level", 0, 32'(d_lv[0]), 0);
    chk("rst_empty", 0, 32'(d_empty[0]), 1);
    chk("rst_aempty", 0, 32'(d_ae[0]), 1);
    chk("rst_afull", 0, 32'(d_af[0]), 0);
    rst_n = 1'b1;

    // Fill the depth-8 FIFO with 0x11..0x18
    for (int k = 1; k <= 8; k++) begin
      wr  = 1'b1;
      din = 8'(8'h10 + k);
      cycle();
      chk("fill_level", 0, 32'(d_lv[0]), 32'(k));
      chk("fill_afull", 0, 32'(d_af[0]), 32'(k >= 4));
    end
    chk("fill_full", 0, 32'(d_full[0]), 1);
    chk("model_fill", 0, 32'(mq[0].size()), 8);

    din = 8'h99;
    cycle();
    chk("ovf_set", 0, 32'(d_ovf[0]), 1);
    chk("ovf_level", 0, 32'(d_lv[0]), 8);

    wr  = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("ovf_clr", 0, 32'(d_ovf[0]), 0);

    // Pop and push on full
    rd  = 1'b1;
    wr  = 1'b1;
    din = 8'hAA;
    cycle();
    chk("fullrw_dout", 0, 32'(d_out[0]), 32'h11);
    chk("fullrw_dv", 0, 32'(d_dv[0]), 1);
    chk("fullrw_level", 0, 32'(d_lv[0]), 8);
    chk("fullrw_ovf", 0, 32'(d_ovf[0]), 0);

    wr = 1'b0;
    exp_rd = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hAA};
    for (int j = 0; j < 8; j++) begin
      cycle();
      chk("drain_dout", 0, 32'(d_out[0]), 32'(exp_rd[j]));
      chk("drain_dv", 0, 32'(d_dv[0]), 1);
    end
    rd = 1'b0;
    cycle();
    chk("drain_empty", 0, 32'(d_empty[0]), 1);
    chk("drain_dv_low", 0, 32'(d_dv[0]), 0);

    // Read and write together on empty
    rd  = 1'b1;
    wr  = 1'b1;
    din = 8'h5C;
    cycle();
    chk("emptyrw_unf", 0, 32'(d_unf[0]), 1);
    chk("emptyrw_level", 0, 32'(d_lv[0]), 1);
    wr = 1'b0;
    cycle();
    chk("emptyrw_dout", 0, 32'(d_out[0]), 32'h5C);
    clr = 1'b1;
    cycle();
    chk("unf_set_wins", 0, 32'(d_unf[0]), 1);
    rd = 1'b0;
    cycle();
    clr = 1'b0;
    chk("unf_clr", 0, 32'(d_unf[0]), 0);

    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_level", 2, 32'(d_lv[2]), 0);

    // First-word-fall-through visibility
    wr  = 1'b1;
    din = 8'h3C;
    cycle();
    wr = 1'b0;
    chk("fwft_dout", 1, 32'(d_out[1]), 32'h3C);
    chk("fwft_dv", 1, 32'(d_dv[1]), 1);
    rd = 1'b1;
    cycle();
    rd = 1'b0;
    chk("fwft_pop_dv", 1, 32'(d_dv[1]), 0);
    chk("fwft_pop_empty", 1, 32'(d_empty[1]), 1);

    // Async reset in the middle of a write burst
    wr = 1'b1;
    for (int k = 0; k < 37; k++) begin
      din = 8'($urandom);
      cycle();
    end
    chk("burst_level", 2, 32'(d_lv[2]), 37);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midrst_level", 2, 32'(d_lv[2]), 0);
    chk("midrst_empty", 2, 32'(d_empty[2]), 1);
    chk("midrst_dv", 3, 32'(d_dv[3]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr    = 1'b0;

    // Randomised traffic with varying fill pressure
    pw = 50;
    pr = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 3))
          0:       begin pw = 90; pr = 20; end
          1:       begin pw = 20; pr = 90; end
          2:       begin pw = 60; pr = 55; end
          default: begin pw = 98; pr = 97; end
        endcase
      end
      wr    = ($urandom_range(0, 99) < pw);
      rd    = ($urandom_range(0, 99) < pr);
      din   = 8'($urandom);
      flush = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
